// File: rtl/rgb_to_grayscale_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rgb_to_grayscale_pipe_if                                                   |
// | Pixel stream bundle: RGB input side and grayscale output side.             |
// | thresh_i exists only when GRAYSCALE_THRESHOLD_EN is defined.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface rgb_to_grayscale_pipe_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] red_i;
    logic [DATA_W-1:0] green_i;
    logic [DATA_W-1:0] blue_i;
    logic [1:0]        mode_i;
    logic              sof_i;
    logic              done_i;
    logic              ready_o;
    logic [DATA_W-1:0] grayscale_o;
    logic              done_o;
    logic              eol_o;
    logic              ready_i;
`ifdef GRAYSCALE_THRESHOLD_EN
    logic [DATA_W-1:0] thresh_i;

    modport master (
        output red_i, green_i, blue_i, mode_i, sof_i, done_i, ready_i, thresh_i,
        input  ready_o, grayscale_o, done_o, eol_o
    );

    modport slave (
        input  red_i, green_i, blue_i, mode_i, sof_i, done_i, ready_i, thresh_i,
        output ready_o, grayscale_o, done_o, eol_o
    );
`else
    modport master (
        output red_i, green_i, blue_i, mode_i, sof_i, done_i, ready_i,
        input  ready_o, grayscale_o, done_o, eol_o
    );

    modport slave (
        input  red_i, green_i, blue_i, mode_i, sof_i, done_i, ready_i,
        output ready_o, grayscale_o, done_o, eol_o
    );
`endif
endinterface
`default_nettype wire

// File: rtl/rgb_to_grayscale_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rgb_to_grayscale_pipe                                                      |
// | Input register plus weight/sum/round stages; optional binary threshold     |
// | enabled by the GRAYSCALE_THRESHOLD_EN macro.                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rgb_to_grayscale_pipe #(
    parameter int DATA_W    = 8,
    parameter int IMG_WIDTH = 512
) (
    input  logic                   clk,
    input  logic                   rst,
    rgb_to_grayscale_pipe_if.slave pix
);
    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int PW = DATA_W + 8;
    localparam int SW = DATA_W + 10;
    localparam int RW = DATA_W + 2;
    localparam logic [CW-1:0]     LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};
    localparam logic [SW-1:0]     ROUND    = SW'(128);

    logic adv;
    logic in_xfer;

    assign adv         = pix.ready_i | ~pix.done_o;
    assign pix.ready_o = adv;
    assign in_xfer     = pix.done_i & adv;

    logic [CW-1:0] col_q, col_d, pix_col;

    // sof_i only matters on an accepted pixel, so it is folded into pix_col
    always_comb begin
        pix_col = pix.sof_i ? '0 : col_q;
        col_d   = col_q;
        if (in_xfer) begin
            col_d = (pix_col == LAST_COL) ? '0 : pix_col + CW'(1);
        end
    end

    logic              s0_vld_q;
    logic [DATA_W-1:0] s0_r_q, s0_g_q, s0_b_q;
    logic [1:0]        s0_mode_q;
    logic              s0_eol_q;

    logic              s1_vld_q;
    logic [PW-1:0]     s1_pr_q, s1_pg_q, s1_pb_q;
    logic [PW-1:0]     s1_pr_d, s1_pg_d, s1_pb_d;
    logic [DATA_W-1:0] s1_max_q, s1_max_d;
    logic              s1_max_sel_q;
    logic              s1_eol_q;

    logic              s2_vld_q;
    logic [RW-1:0]     s2_res_q, s2_res_d;
    logic              s2_eol_q;

    logic              done_q;
    logic              eol_q;
    logic [DATA_W-1:0] gray_q, gray_d;

`ifdef GRAYSCALE_THRESHOLD_EN
    logic [DATA_W-1:0] s0_thr_q, s1_thr_q, s2_thr_q;
`endif

    logic [7:0] wt_r, wt_g, wt_b;

    always_comb begin
        wt_r = 8'd54;
        wt_g = 8'd183;
        wt_b = 8'd19;
        case (s0_mode_q)
            2'd0: begin
                wt_r = 8'd85;
                wt_g = 8'd86;
                wt_b = 8'd85;
            end
            2'd1: begin
                wt_r = 8'd77;
                wt_g = 8'd150;
                wt_b = 8'd29;
            end
            default: ;
        endcase
        s1_pr_d  = PW'(s0_r_q) * PW'(wt_r);
        s1_pg_d  = PW'(s0_g_q) * PW'(wt_g);
        s1_pb_d  = PW'(s0_b_q) * PW'(wt_b);
        s1_max_d = s0_r_q;
        if (s0_g_q > s1_max_d) s1_max_d = s0_g_q;
        if (s0_b_q > s1_max_d) s1_max_d = s0_b_q;
    end

    logic [SW-1:0] sum;

    always_comb begin
        sum      = SW'(s1_pr_q) + SW'(s1_pg_q) + SW'(s1_pb_q) + ROUND;
        s2_res_d = s1_max_sel_q ? RW'(s1_max_q) : RW'(sum >> 8);
    end

    logic [DATA_W-1:0] sat;

    // weights sum to 256 so saturation is a guard, not an expected path
    always_comb begin
        sat    = (s2_res_q > RW'(ALL_ONES)) ? ALL_ONES : s2_res_q[DATA_W-1:0];
        gray_d = sat;
`ifdef GRAYSCALE_THRESHOLD_EN
        if (s2_thr_q != '0) begin
            gray_d = (sat >= s2_thr_q) ? ALL_ONES : '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q        <= '0;
            s0_vld_q     <= 1'b0;
            s0_r_q       <= '0;
            s0_g_q       <= '0;
            s0_b_q       <= '0;
            s0_mode_q    <= '0;
            s0_eol_q     <= 1'b0;
            s1_vld_q     <= 1'b0;
            s1_pr_q      <= '0;
            s1_pg_q      <= '0;
            s1_pb_q      <= '0;
            s1_max_q     <= '0;
            s1_max_sel_q <= 1'b0;
            s1_eol_q     <= 1'b0;
            s2_vld_q     <= 1'b0;
            s2_res_q     <= '0;
            s2_eol_q     <= 1'b0;
            done_q       <= 1'b0;
            eol_q        <= 1'b0;
            gray_q       <= '0;
`ifdef GRAYSCALE_THRESHOLD_EN
            s0_thr_q     <= '0;
            s1_thr_q     <= '0;
            s2_thr_q     <= '0;
`endif
        end else begin
            col_q <= col_d;
            if (adv) begin
                s0_vld_q     <= pix.done_i;
                s0_r_q       <= pix.red_i;
                s0_g_q       <= pix.green_i;
                s0_b_q       <= pix.blue_i;
                s0_mode_q    <= pix.mode_i;
                s0_eol_q     <= (pix_col == LAST_COL);
                s1_vld_q     <= s0_vld_q;
                s1_pr_q      <= s1_pr_d;
                s1_pg_q      <= s1_pg_d;
                s1_pb_q      <= s1_pb_d;
                s1_max_q     <= s1_max_d;
                s1_max_sel_q <= (s0_mode_q == 2'd3);
                s1_eol_q     <= s0_eol_q;
                s2_vld_q     <= s1_vld_q;
                s2_res_q     <= s2_res_d;
                s2_eol_q     <= s1_eol_q;
                done_q       <= s2_vld_q;
                eol_q        <= s2_eol_q;
                gray_q       <= gray_d;
`ifdef GRAYSCALE_THRESHOLD_EN
                s0_thr_q     <= pix.thresh_i;
                s1_thr_q     <= s0_thr_q;
                s2_thr_q     <= s1_thr_q;
`endif
            end
        end
    end

    assign pix.done_o      = done_q;
    assign pix.eol_o       = eol_q;
    assign pix.grayscale_o = gray_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_to_grayscale_pipe.sv
`default_nettype none
// Scoreboarded random + directed bench for rgb_to_grayscale_pipe
// (DATA_W=8, IMG_WIDTH=4 so end-of-line tagging is exercised often).
module tb_rgb_to_grayscale_pipe;
    localparam int DW   = 8;
    localparam int IW   = 4;
    localparam int MAXI = (1 << DW) - 1;
`ifdef GRAYSCALE_THRESHOLD_EN
    localparam bit THR_EN = 1'b1;
`else
    localparam bit THR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] g;
        logic          e;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rgb_to_grayscale_pipe_if #(.DATA_W(DW)) pif ();

    rgb_to_grayscale_pipe #(.DATA_W(DW), .IMG_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .pix (pif)
    );

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   col_m    = 0;
    int   ready_mode = 0;
    int   stall_req  = 0;
    int   stall_left = 0;
    int   lat_ref    = -1;
    bit   lat_arm    = 1'b0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic          stalled_prev = 1'b0;
    logic [DW-1:0] g_prev;
    logic          e_prev;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] model(input int r, input int g, input int b,
                                            input int m, input int thr);
        int s;
        int res;
        case (m)
            0:       s = 85 * r + 86 * g + 85 * b;
            1:       s = 77 * r + 150 * g + 29 * b;
            2:       s = 54 * r + 183 * g + 19 * b;
            default: s = 0;
        endcase
        if (m == 3) begin
            res = r;
            if (g > res) res = g;
            if (b > res) res = b;
        end else begin
            res = (s + 128) / 256;
            if (res > MAXI) res = MAXI;
        end
        if (THR_EN && thr != 0) res = (res >= thr) ? MAXI : 0;
        return res[DW-1:0];
    endfunction

    // exp_g / exp_e < 0 means "take the value from the reference model"
    task automatic send(input logic [DW-1:0] r, input logic [DW-1:0] g, input logic [DW-1:0] b,
                        input logic [1:0] m, input logic sof, input logic [DW-1:0] thr,
                        input int exp_g, input int exp_e);
        exp_t e;
        int   col;
        int   tries;
        @(negedge clk);
        pif.red_i   = r;
        pif.green_i = g;
        pif.blue_i  = b;
        pif.mode_i  = m;
        pif.sof_i   = sof;
        pif.done_i  = 1'b1;
`ifdef GRAYSCALE_THRESHOLD_EN
        pif.thresh_i = thr;
`endif
        tries = 0;
        #1;
        while (!pif.ready_o && tries < 100) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (!pif.ready_o) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout ready_o=%0b required=1", pif.ready_o);
            pif.done_i = 1'b0;
            return;
        end
        col   = sof ? 0 : col_m;
        e.g   = (exp_g >= 0) ? exp_g[DW-1:0] : model(r, g, b, m, thr);
        e.e   = (exp_e >= 0) ? exp_e[0] : (col == IW - 1);
        col_m = (col == IW - 1) ? 0 : col + 1;
        sb_q.push_back(e);
        if (lat_arm) begin
            lat_ref = cyc + 1;
            lat_arm = 1'b0;
        end
        @(posedge clk);
        #1;
        pif.done_i = 1'b0;
    endtask

    // idle cycles with junk data and sof_i=1, which must be ignored
    task automatic bubble(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pif.done_i  = 1'b0;
            pif.sof_i   = 1'b1;
            pif.red_i   = DW'($urandom);
            pif.mode_i  = 2'($urandom);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin : ready_gen
        pif.ready_i = 1'b1;
        forever begin
            @(negedge clk);
            if (stall_req > 0) begin
                stall_left = stall_req;
                stall_req  = 0;
            end
            if (stall_left > 0) begin
                pif.ready_i = 1'b0;
                stall_left--;
            end else if (ready_mode == 1) begin
                pif.ready_i = ($urandom_range(3) != 0);
            end else begin
                pif.ready_i = 1'b1;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                checks++;
                if (pif.done_o !== 1'b0 || pif.grayscale_o !== '0 || pif.eol_o !== 1'b0 ||
                    pif.ready_o !== 1'b1) begin
                    failures++;
                    $display("FAIL reset_values done=%0b gray=%0d eol=%0b ready=%0b required 0/0/0/1",
                             pif.done_o, pif.grayscale_o, pif.eol_o, pif.ready_o);
                end
                stalled_prev = 1'b0;
            end else begin
                if (stalled_prev) begin
                    checks++;
                    if (pif.done_o !== 1'b1 || pif.grayscale_o !== g_prev || pif.eol_o !== e_prev) begin
                        failures++;
                        $display("FAIL stall_hold got=%0b/%0d/%0b required=1/%0d/%0b",
                                 pif.done_o, pif.grayscale_o, pif.eol_o, g_prev, e_prev);
                    end
                end
                if (pif.done_o && !pif.ready_i) begin
                    checks++;
                    if (pif.ready_o !== 1'b0) begin
                        failures++;
                        $display("FAIL ready_o_stall got=%0b required=0", pif.ready_o);
                    end
                end
                if (lat_ref >= 0 && pif.done_o) begin
                    checks++;
                    if (cyc - lat_ref != 3) begin
                        failures++;
                        $display("FAIL latency got=%0d required=3", cyc - lat_ref);
                    end
                    lat_ref = -1;
                end
                if (pif.done_o && pif.ready_i) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_output gray=%0d required none", pif.grayscale_o);
                    end else begin
                        mon_e = sb_q.pop_front();
                        if (pif.grayscale_o !== mon_e.g || pif.eol_o !== mon_e.e) begin
                            failures++;
                            $display("FAIL pixel gray/eol got=%0d/%0b required=%0d/%0b",
                                     pif.grayscale_o, pif.eol_o, mon_e.g, mon_e.e);
                        end
                    end
                end
                stalled_prev = pif.done_o && !pif.ready_i;
                g_prev       = pif.grayscale_o;
                e_prev       = pif.eol_o;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        failures++;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int k;
        logic sof;
        pif.red_i   = '0;
        pif.green_i = '0;
        pif.blue_i  = '0;
        pif.mode_i  = 2'd0;
        pif.sof_i   = 1'b0;
        pif.done_i  = 1'b0;
`ifdef GRAYSCALE_THRESHOLD_EN
        pif.thresh_i = '0;
`endif
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // continuous mode-1 stream with first-output latency check
        lat_arm = 1'b1;
        for (int i = 0; i < 8; i++) send(8'd200, 8'd200, 8'd200, 2'd1, 1'b0, '0, 200, -1);

        // interleaved modes with hand-computed results
        send(8'd255, 8'd0,   8'd0,  2'd0, 1'b0, '0, 85,  -1);
        send(8'd0,   8'd255, 8'd0,  2'd2, 1'b0, '0, 182, -1);
        send(8'd10,  8'd240, 8'd30, 2'd3, 1'b0, '0, 240, -1);
        send(8'd255, 8'd0,   8'd0,  2'd0, 1'b0, '0, 85,  -1);
        send(8'd10,  8'd240, 8'd30, 2'd3, 1'b0, '0, 240, -1);
        send(8'd255, 8'd255, 8'd255, 2'd1, 1'b0, '0, 255, -1);
        bubble(2);

        // end-of-line tagging with sof on pixels 0 and 6
        for (int i = 0; i < 10; i++) begin
            send(DW'($urandom), DW'($urandom), DW'($urandom), 2'($urandom), (i == 0 || i == 6),
                 '0, -1, (i == 3 || i == 9) ? 1 : 0);
        end
        drain();

        // 20-pixel burst with a 5-cycle downstream stall in the middle
        for (int i = 0; i < 20; i++) begin
            if (i == 10) stall_req = 5;
            send(DW'($urandom), DW'($urandom), DW'($urandom), 2'($urandom), 1'b0, '0, -1, -1);
        end
        drain();

`ifdef GRAYSCALE_THRESHOLD_EN
        send(8'd127, 8'd127, 8'd127, 2'd1, 1'b0, 8'd128, 0,   -1);
        send(8'd128, 8'd128, 8'd128, 2'd1, 1'b0, 8'd128, 255, -1);
        send(8'd128, 8'd128, 8'd128, 2'd1, 1'b0, 8'd0,   128, -1);
        drain();
`endif

        // asynchronous reset with pixels in flight
        for (int i = 0; i < 3; i++) send(8'd50, 8'd60, 8'd70, 2'd1, 1'b0, '0, -1, -1);
        k = 0;
        do begin
            @(negedge clk);
            #3;
            k++;
        end while (!pif.done_o && k < 10);
        rst = 1'b0;
        #1;
        checks++;
        if (pif.done_o !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_drop done_o=%0b required=0", pif.done_o);
        end
        sb_q.delete();
        col_m = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bubble(6);

        // first pixel after reset must sit at column 0
        for (int i = 0; i < 4; i++) send(8'd1, 8'd2, 8'd3, 2'd0, 1'b0, '0, -1, (i == 3) ? 1 : 0);
        drain();

        // randomized traffic with bubbles and random backpressure
        ready_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) begin
                bubble(1);
            end else begin
                sof = ($urandom_range(15) == 0);
                send(DW'($urandom), DW'($urandom), DW'($urandom), 2'($urandom), sof,
                     ($urandom_range(1) == 0) ? '0 : DW'($urandom), -1, -1);
            end
        end
        ready_mode = 0;
        drain();
        bubble(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
